dma_dh_burst: RTL and testbench
===============================

Name: dma_dh_burst

Overview:
TX DMA data handler that replaces the single-shot segment fetcher. It takes a frame request from the TX command path and walks the PRD segments returned by the address-lookup (AL) block, splitting each segment into NPI read bursts that never cross a C_MAX_BURST boundary. Read data is framed into 72-bit TX link-layer words carrying SOF/EOF codes, including a half-word EOF code for frames whose length is an odd number of dwords. It adds dh_abort with NPI drain and TX-FIFO-space gating per burst.

Parameters:
C_BIG_ENDIAN, 1, 1 = byte-swap each 64-bit NPI beat (byte i ↔ byte 7-i); 0 = pass through.
C_LEN_W, 14, width of all byte-length fields.
C_MAX_BURST, 512, maximum NPI burst in bytes; power of two, 8..2^(C_LEN_W-1).

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous reset, active high
tx2dh_req  in  1  frame request, level; sampled in IDLE
tx2dh_len  in  C_LEN_W  frame bytes; bits[1:0] ignored
dh2tx_ack  out  1  one-cycle pulse, frame complete
dh2tx_err  out  1  level; AL error or zero length
dh_abort  in  1  abort current frame
tx2al_req  out  1  segment request, held until al2dh_ack
tx2al_len  out  C_LEN_W  remaining frame bytes
al2dh_ack / al2dh_err / al2dh_last  in  1  segment response; last = final PRD
al2dh_addr  in  32  segment byte address, 8-byte aligned
al2dh_len  in  C_LEN_W  segment bytes
npi_addr  out  36  burst address, {4'b0, addr}
npi_len  out  C_LEN_W  burst bytes
npi_req  out  1  burst request, held until npi_ack
npi_ack  in  1  burst accepted
npi_data  in  64  read beat
npi_valid / npi_last  in  1  beat valid / final beat of burst
txdma2txll_do  out  72  {d3p[3:0], d7p[3:0], data0[31:0], data1[31:0]}
txdma2txll_push  out  1  write strobe
txll2txdma_rdy  in  1  TX FIFO can take one full C_MAX_BURST
txdmadh2dbg  out  32  [3:0] state, [4] sof pending, [5] final burst, [31:16] remaining bytes

Behaviour:
- Reset: state IDLE. All outputs 0. Internal remaining/segment counters 0.
- The reset covers sys_rst only. dh_abort is handled separately below.
- IDLE:
  - On tx2dh_req, latch rem = tx2dh_len & ~3 and set sof_pend = 1.
  - If rem == 0, go to ERROR; otherwise go to AREQ.
- AREQ:
  - Drive tx2al_req = 1 and tx2al_len = rem.
  - On al2dh_ack & ~al2dh_err: seg_addr = al2dh_addr, seg_len = min(al2dh_len & ~3, rem), seg_last = al2dh_last; go to BURST.
  - On al2dh_err, go to ERROR. al2dh_err takes priority over ack.
  - A zero seg_len is an error and goes to ERROR.
- BURST:
  - blen = min(seg_len, C_MAX_BURST − (seg_addr mod C_MAX_BURST)).
  - final = (blen == rem) | (blen == seg_len & seg_last).
  - Assert npi_req only while txll2txdma_rdy = 1 in the cycle before.
  - npi_addr and npi_len stay stable from npi_req until npi_ack. On npi_ack, go to DATA.
- DATA:
  - Forward beats. On npi_valid & npi_last, go to POST.
  - A beat arriving in the same cycle as npi_ack is legal.
- POST:
  - seg_addr += blen, seg_len −= blen, rem −= blen.
  - If final, go to DONE. Else if seg_len == 0, go to AREQ. Else go to BURST.
- DONE: dh2tx_ack = 1 for one cycle, then IDLE.
- ERROR: dh2tx_err stays high; leave only on dh_abort or sys_rst.
- Framing, per npi_valid beat, registered, 1-cycle latency to push:
  - data0 = swapped[63:32], data1 = swapped[31:0].
  - d3p = 1010 when sof_pend (sof_pend then clears); else 0000.
  - d7p = 0100 on the final beat of a final burst when rem mod 8 == 0.
  - d7p = 0110 on that beat when rem mod 8 == 4 (data1 invalid).
  - d7p = 0000 otherwise.
  - A single-beat frame carries SOF and EOF together.
  - push = 0 when no beat.
- dh_abort, highest priority after sys_rst:
  - In DATA, or on npi_ack in BURST: go to DRAIN, discard beats with no push until npi_valid & npi_last, then IDLE.
  - In any other state: go to IDLE next cycle.
  - No ack and no err is raised. dh2tx_err clears.
- A burst never exceeds seg_len or rem. Counters never underflow.

Decomposition:
- Shared package dma_dh_pkg holds:
  - state encoding: IDLE, AREQ, BURST, DATA, POST, DONE, ERROR, DRAIN;
  - framing codes: CTL_SOF = 4'b1010, CTL_EOF = 4'b0100, CTL_EOF_HALF = 4'b0110;
  - a byte-swap function.
- One sub-module, dma_dh_framer: registered beat formatter (swap, SOF/EOF insertion, push). The FSM and burst arithmetic stay in the top module.

Test Plan:
- Boundary split: len 1024, one PRD at 0x1000_0100 len 1024 last, C_MAX_BURST 512 → bursts (0x1000_0100, 256), (0x1000_0200, 512), (0x1000_0400, 256); 128 pushes; SOF on push 1, EOF 0100 on push 128; one ack pulse.
- Odd dword: len 12, PRD len 12 → 2 pushes; second push has d7p = 0110.
- Multi-PRD: len 24, PRD0 (0x2000, 8, last=0), PRD1 (0x3000, 16, last=1) → 2 AL requests (tx2al_len 24, then 16); 3 pushes; SOF only on push 1, EOF on push 3.
- Error: al2dh_err on first AREQ → dh2tx_err = 1 and stays high, no npi_req; dh_abort → IDLE, err = 0.
- Abort drain: 32-byte burst, dh_abort after beat 2 → beats 3–4 produce no push; IDLE after npi_last; no ack.
- Backpressure: txll2txdma_rdy = 0 for 10 cycles in BURST → npi_req stays 0; asserted the cycle after rdy rises.

Source files
------------

// File: rtl/dma_dh_pkg.sv
// dma_dh_pkg: shared state encoding, framing codes and byte swap for the TX DMA data handler
package dma_dh_pkg;
    typedef enum logic [3:0] {IDLE, AREQ, BURST, DATA, POST, DONE, ERROR, DRAIN} dh_state_t;
    localparam logic [3:0] CTL_SOF      = 4'b1010;
    localparam logic [3:0] CTL_EOF      = 4'b0100;
    localparam logic [3:0] CTL_EOF_HALF = 4'b0110;
    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
        return r;
    endfunction
endpackage

// File: rtl/dma_dh_framer.sv
// dma_dh_framer: registered NPI beat to TX link-layer word formatter with SOF/EOF codes
module dma_dh_framer
    import dma_dh_pkg::*;
#(
    parameter int C_BIG_ENDIAN = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    input  logic        i_sof,
    input  logic        i_eof,
    input  logic        i_half,
    output logic [71:0] o_do,
    output logic        o_push
);
    logic [63:0] w_sw;
    logic [3:0]  w_d3p, w_d7p;
    assign w_sw  = (C_BIG_ENDIAN != 0) ? bswap64(i_data) : i_data;
    assign w_d3p = i_sof ? CTL_SOF : 4'b0000;
    assign w_d7p = i_eof ? (i_half ? CTL_EOF_HALF : CTL_EOF) : 4'b0000;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_push <= 1'b0;
            o_do   <= '0;
        end else begin
            o_push <= i_valid;
            if (i_valid) o_do <= {w_d3p, w_d7p, w_sw};
        end
    end
endmodule

// File: rtl/dma_dh_burst.sv
// dma_dh_burst: TX DMA data handler walking PRD segments as boundary-safe NPI bursts
module dma_dh_burst
    import dma_dh_pkg::*;
#(
    parameter int C_BIG_ENDIAN = 1,
    parameter int C_LEN_W      = 14,
    parameter int C_MAX_BURST  = 512
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               tx2dh_req,
    input  logic [C_LEN_W-1:0] tx2dh_len,
    output logic               dh2tx_ack,
    output logic               dh2tx_err,
    input  logic               dh_abort,
    output logic               tx2al_req,
    output logic [C_LEN_W-1:0] tx2al_len,
    input  logic               al2dh_ack,
    input  logic               al2dh_err,
    input  logic               al2dh_last,
    input  logic [31:0]        al2dh_addr,
    input  logic [C_LEN_W-1:0] al2dh_len,
    output logic [35:0]        npi_addr,
    output logic [C_LEN_W-1:0] npi_len,
    output logic               npi_req,
    input  logic               npi_ack,
    input  logic [63:0]        npi_data,
    input  logic               npi_valid,
    input  logic               npi_last,
    output logic [71:0]        txdma2txll_do,
    output logic               txdma2txll_push,
    input  logic               txll2txdma_rdy,
    output logic [31:0]        txdmadh2dbg
);
    localparam int LB = $clog2(C_MAX_BURST);
    dh_state_t r_state, w_next;
    logic [C_LEN_W-1:0] r_rem, r_seg_len, r_blen;
    logic [C_LEN_W-1:0] w_len_in, w_al_len, w_seg_len, w_room, w_blen;
    logic [31:0] r_seg_addr;
    logic r_seg_last, r_sof_pend, r_final, r_npi_req;
    logic w_final, w_acc, w_end, w_fwd;
    assign w_len_in  = tx2dh_len & ~C_LEN_W'(3);
    assign w_al_len  = al2dh_len & ~C_LEN_W'(3);
    assign w_seg_len = (w_al_len < r_rem) ? w_al_len : r_rem;
    // Room left before the next C_MAX_BURST address boundary
    assign w_room    = C_LEN_W'(C_MAX_BURST) - C_LEN_W'(r_seg_addr[LB-1:0]);
    assign w_blen    = (r_seg_len < w_room) ? r_seg_len : w_room;
    assign w_final   = (w_blen == r_rem) | ((w_blen == r_seg_len) & r_seg_last);
    assign w_acc     = (r_state == BURST) & r_npi_req & npi_ack;
    assign w_end     = npi_valid & npi_last;
    assign w_fwd     = npi_valid & ~dh_abort & ((r_state == DATA) | w_acc);
    always_comb begin
        w_next = r_state;
        if (dh_abort)
            w_next = ((r_state == DATA) | (r_state == DRAIN) | w_acc) ? (w_end ? IDLE : DRAIN) : IDLE;
        else
            case (r_state)
                IDLE:    if (tx2dh_req) w_next = (w_len_in == '0) ? ERROR : AREQ;
                AREQ:    if (al2dh_err) w_next = ERROR;
                         else if (al2dh_ack) w_next = (w_seg_len == '0) ? ERROR : BURST;
                BURST:   if (w_acc) w_next = w_end ? POST : DATA;
                DATA:    if (w_end) w_next = POST;
                POST:    w_next = r_final ? DONE : (r_seg_len == r_blen) ? AREQ : BURST;
                DONE:    w_next = IDLE;
                ERROR:   w_next = ERROR;
                DRAIN:   if (w_end) w_next = IDLE;
                default: w_next = IDLE;
            endcase
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_next;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rem      <= '0;
            r_seg_len  <= '0;
            r_seg_addr <= '0;
            r_seg_last <= 1'b0;
            r_blen     <= '0;
            r_final    <= 1'b0;
            r_sof_pend <= 1'b0;
            r_npi_req  <= 1'b0;
        end else begin
            if ((r_state == IDLE) & tx2dh_req & ~dh_abort) begin
                r_rem      <= w_len_in;
                r_sof_pend <= 1'b1;
            end
            if ((r_state == AREQ) & al2dh_ack & ~al2dh_err) begin
                r_seg_addr <= al2dh_addr;
                r_seg_len  <= w_seg_len;
                r_seg_last <= al2dh_last;
            end
            // Burst geometry is frozen from request to acknowledge
            if ((r_state == BURST) & ~r_npi_req) begin
                r_blen  <= w_blen;
                r_final <= w_final;
            end
            r_npi_req <= (r_state == BURST) & ~dh_abort & (r_npi_req ? ~npi_ack : txll2txdma_rdy);
            if (r_state == POST) begin
                r_seg_addr <= r_seg_addr + 32'(r_blen);
                r_seg_len  <= r_seg_len - r_blen;
                r_rem      <= r_rem - r_blen;
            end
            if (w_fwd) r_sof_pend <= 1'b0;
        end
    end
    assign dh2tx_ack   = (r_state == DONE);
    assign dh2tx_err   = (r_state == ERROR);
    assign tx2al_req   = (r_state == AREQ);
    assign tx2al_len   = r_rem;
    assign npi_req     = r_npi_req;
    assign npi_addr    = {4'b0000, r_seg_addr};
    assign npi_len     = r_blen;
    assign txdmadh2dbg = {16'(r_rem), 10'd0, r_final, r_sof_pend, r_state};
    dma_dh_framer #(.C_BIG_ENDIAN(C_BIG_ENDIAN)) u_framer (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_valid (w_fwd),
        .i_data  (npi_data),
        .i_sof   (r_sof_pend),
        .i_eof   (r_final & npi_last),
        .i_half  (r_rem[2]),
        .o_do    (txdma2txll_do),
        .o_push  (txdma2txll_push)
    );
endmodule

// File: tb/tb_dma_dh_burst.sv
// tb_dma_dh_burst: scoreboard bench for the TX DMA burst data handler
module tb_dma_dh_burst;
    localparam int LW = 14;
    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          tx2dh_req = 1'b0;
    logic [LW-1:0] tx2dh_len = '0;
    logic          dh2tx_ack, dh2tx_err;
    logic          dh_abort = 1'b0;
    logic          tx2al_req;
    logic [LW-1:0] tx2al_len;
    logic          al2dh_ack = 1'b0, al2dh_err = 1'b0, al2dh_last = 1'b0;
    logic [31:0]   al2dh_addr = '0;
    logic [LW-1:0] al2dh_len = '0;
    logic [35:0]   npi_addr;
    logic [LW-1:0] npi_len;
    logic          npi_req;
    logic          npi_ack = 1'b0;
    logic [63:0]   npi_data = '0;
    logic          npi_valid = 1'b0, npi_last = 1'b0;
    logic [71:0]   txdma2txll_do;
    logic          txdma2txll_push;
    logic          txll2txdma_rdy = 1'b1;
    logic [31:0]   txdmadh2dbg;

    always #5 sys_clk = ~sys_clk;

    dma_dh_burst #(.C_BIG_ENDIAN(1), .C_LEN_W(LW), .C_MAX_BURST(512)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .tx2dh_req(tx2dh_req), .tx2dh_len(tx2dh_len),
        .dh2tx_ack(dh2tx_ack), .dh2tx_err(dh2tx_err), .dh_abort(dh_abort),
        .tx2al_req(tx2al_req), .tx2al_len(tx2al_len),
        .al2dh_ack(al2dh_ack), .al2dh_err(al2dh_err), .al2dh_last(al2dh_last),
        .al2dh_addr(al2dh_addr), .al2dh_len(al2dh_len),
        .npi_addr(npi_addr), .npi_len(npi_len), .npi_req(npi_req), .npi_ack(npi_ack),
        .npi_data(npi_data), .npi_valid(npi_valid), .npi_last(npi_last),
        .txdma2txll_do(txdma2txll_do), .txdma2txll_push(txdma2txll_push),
        .txll2txdma_rdy(txll2txdma_rdy), .txdmadh2dbg(txdmadh2dbg)
    );

    logic [71:0] sb[$];
    int n_chk = 0, n_pass = 0, ack_cnt = 0, push_cnt = 0;
    bit sof_exp;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    initial forever begin
        @(negedge sys_clk);
        if (dh2tx_ack) ack_cnt++;
        if (txdma2txll_push) begin
            push_cnt++;
            if (sb.size() == 0) chk("push_unexpected", txdma2txll_push, 0);
            else chk("push_word", txdma2txll_do, sb.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic start_frame(input int len);
        ack_cnt = 0; push_cnt = 0; sof_exp = 1'b1;
        tx2dh_len = LW'(len); tx2dh_req = 1'b1;
        @(negedge sys_clk);
        tx2dh_req = 1'b0;
    endtask

    task automatic wait_al;
        int n = 0;
        while (!tx2al_req && n < 100) begin @(negedge sys_clk); n++; end
        chk("al_req", tx2al_req, 1);
    endtask

    task automatic al_resp(input logic [31:0] a, input int len, input bit last, input int exp_rem);
        wait_al();
        chk("al_len", tx2al_len, exp_rem);
        al2dh_ack = 1'b1; al2dh_addr = a; al2dh_len = LW'(len); al2dh_last = last;
        @(negedge sys_clk);
        al2dh_ack = 1'b0;
    endtask

    task automatic burst(input logic [31:0] a, input int len, input bit eof, input bit half, input int abort_beat);
        int n = 0;
        int nb = (len + 7) / 8;
        logic [63:0] d, sw;
        while (!npi_req && n < 100) begin @(negedge sys_clk); n++; end
        chk("npi_req", npi_req, 1);
        chk("npi_addr", npi_addr, {4'b0, a});
        chk("npi_len", npi_len, len);
        npi_ack = 1'b1;
        @(negedge sys_clk);
        npi_ack = 1'b0;
        for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom};
            sw = {<<8{d}};
            npi_data = d; npi_valid = 1'b1; npi_last = (b == nb - 1); dh_abort = (b == abort_beat);
            if (abort_beat < 0 || b < abort_beat) begin
                sb.push_back({sof_exp ? 4'b1010 : 4'b0000,
                              (eof && b == nb - 1) ? (half ? 4'b0110 : 4'b0100) : 4'b0000, sw});
                sof_exp = 1'b0;
            end
            @(negedge sys_clk);
        end
        npi_valid = 1'b0; npi_last = 1'b0; dh_abort = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int exp_push, input int exp_ack);
        repeat (6) @(negedge sys_clk);
        chk({tag, "_pushes"}, push_cnt, exp_push);
        chk({tag, "_ack"}, ack_cnt, exp_ack);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_idle"}, txdmadh2dbg[3:0], 0);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_ack", dh2tx_ack, 0);
        chk("rst_err", dh2tx_err, 0);
        chk("rst_al_req", tx2al_req, 0);
        chk("rst_npi_req", npi_req, 0);
        chk("rst_push", txdma2txll_push, 0);
        chk("rst_do", txdma2txll_do, 0);
        chk("rst_dbg", txdmadh2dbg, 0);
        chk("rst_npi_len", npi_len, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // 1 KiB frame split across two 512-byte boundaries
        start_frame(1024);
        al_resp(32'h1000_0100, 1024, 1'b1, 1024);
        burst(32'h1000_0100, 256, 1'b0, 1'b0, -1);
        burst(32'h1000_0200, 512, 1'b0, 1'b0, -1);
        burst(32'h1000_0400, 256, 1'b1, 1'b0, -1);
        finish_frame("boundary", 128, 1);

        start_frame(12);
        al_resp(32'h0000_4000, 12, 1'b1, 12);
        burst(32'h0000_4000, 12, 1'b1, 1'b1, -1);
        finish_frame("odd_dword", 2, 1);

        start_frame(24);
        al_resp(32'h0000_2000, 8, 1'b0, 24);
        burst(32'h0000_2000, 8, 1'b0, 1'b0, -1);
        al_resp(32'h0000_3000, 16, 1'b1, 16);
        burst(32'h0000_3000, 16, 1'b1, 1'b0, -1);
        finish_frame("multi_prd", 3, 1);

        start_frame(8);
        al_resp(32'h0000_7000, 8, 1'b1, 8);
        burst(32'h0000_7000, 8, 1'b1, 1'b0, -1);
        finish_frame("single_beat", 1, 1);

        start_frame(64);
        wait_al();
        al2dh_err = 1'b1; al2dh_ack = 1'b1;
        @(negedge sys_clk);
        al2dh_err = 1'b0; al2dh_ack = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("err_high", dh2tx_err, 1);
        chk("err_no_npi", npi_req, 0);
        repeat (5) @(negedge sys_clk);
        chk("err_held", dh2tx_err, 1);
        dh_abort = 1'b1;
        @(negedge sys_clk);
        dh_abort = 1'b0;
        chk("err_cleared", dh2tx_err, 0);
        chk("err_idle", txdmadh2dbg[3:0], 0);
        chk("err_no_ack", ack_cnt, 0);

        start_frame(3);
        chk("zero_len_err", dh2tx_err, 1);
        dh_abort = 1'b1;
        @(negedge sys_clk);
        dh_abort = 1'b0;
        chk("zero_len_cleared", dh2tx_err, 0);

        start_frame(32);
        al_resp(32'h0000_5000, 32, 1'b1, 32);
        burst(32'h0000_5000, 32, 1'b1, 1'b0, 2);
        finish_frame("abort_drain", 2, 0);
        chk("abort_no_err", dh2tx_err, 0);

        txll2txdma_rdy = 1'b0;
        start_frame(16);
        al_resp(32'h0000_6000, 16, 1'b1, 16);
        for (int i = 0; i < 10; i++) begin
            chk("bp_no_req", npi_req, 0);
            @(negedge sys_clk);
        end
        txll2txdma_rdy = 1'b1;
        @(negedge sys_clk);
        chk("bp_req_after_rdy", npi_req, 1);
        burst(32'h0000_6000, 16, 1'b1, 1'b0, -1);
        finish_frame("backpressure", 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
